// File: rtl/tdp_bram_cfg.sv
// rtl/tdp_bram_cfg.sv - true dual-port BRAM with byte enables, selectable write mode and clear engine
module tdp_bram_cfg #(
    parameter int L2_DEPTH   = 8,
    parameter int WIDTH      = 32,
    parameter int BYTE_W     = 8,
    parameter int WRITE_MODE = 0,
    parameter int READ_LAT   = 2,
    parameter int PRIO       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_req,
    output logic                      busy,
    input  logic                      en1,
    input  logic [WIDTH/BYTE_W-1:0]   we1,
    input  logic [L2_DEPTH-1:0]       addr1,
    input  logic [WIDTH-1:0]          din1,
    input  logic                      regce1,
    output logic [WIDTH-1:0]          dout1,
    output logic                      dout1_valid,
    input  logic                      en2,
    input  logic [WIDTH/BYTE_W-1:0]   we2,
    input  logic [L2_DEPTH-1:0]       addr2,
    input  logic [WIDTH-1:0]          din2,
    input  logic                      regce2,
    output logic [WIDTH-1:0]          dout2,
    output logic                      dout2_valid,
    output logic                      collision
);

    localparam int DEPTH = 2 ** L2_DEPTH;
    localparam int NB    = WIDTH / BYTE_W;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [L2_DEPTH-1:0]  clear_addr_q, clear_addr_d;

    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic [WIDTH-1:0]     rd1_q, rd1_d, rd2_q, rd2_d;
    logic                 v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0]     do1_q, do1_d, do2_q, do2_d;
    logic                 dv1_q, dv1_d, dv2_q, dv2_d;
    logic                 coll1_q, coll1_d, coll2_q, coll2_d;

    logic                 en1_m, en2_m, wr1, wr2, same_addr, hit1, hit2;
    logic [WIDTH-1:0]     old1, old2;

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [NB-1:0]    we);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (we[b]) r[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d      = S_CLEAR;
                    clear_addr_d = '0;
                end
            end
            S_CLEAR: begin
                clear_addr_d = clear_addr_q + L2_DEPTH'(1);
                if (clear_addr_q == {L2_DEPTH{1'b1}}) state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    assign en1_m     = en1 & ~busy_q;
    assign en2_m     = en2 & ~busy_q;
    assign wr1       = en1_m & (|we1);
    assign wr2       = en2_m & (|we2);
    assign same_addr = (addr1 == addr2);
    // A port reading an address the other port writes this cycle always sees the old word.
    assign hit1      = en1_m & wr2 & same_addr;
    assign hit2      = en2_m & wr1 & same_addr;
    assign old1      = mem_q[addr1];
    assign old2      = mem_q[addr2];

    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        v1_d    = en1_m & ~((WRITE_MODE == 2) & (|we1));
        v2_d    = en2_m & ~((WRITE_MODE == 2) & (|we2));
        if (v1_d) rd1_d = ((WRITE_MODE == 1) && !hit1) ? merge(old1, din1, we1) : old1;
        if (v2_d) rd2_d = ((WRITE_MODE == 1) && !hit2) ? merge(old2, din2, we2) : old2;
        do1_d   = regce1 ? rd1_q : do1_q;
        do2_d   = regce2 ? rd2_q : do2_q;
        dv1_d   = v1_q & regce1;
        dv2_d   = v2_q & regce2;
        coll1_d = en1_m & en2_m & same_addr & ((|we1) | (|we2));
        coll2_d = coll1_q;
    end

    // Non-priority port is written first so the priority port's lanes land last.
    always_ff @(posedge clk) begin
        if (busy_q) begin
            mem_q[clear_addr_q] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (PRIO == 1) begin
                    if (en2_m && we2[b]) mem_q[addr2][b*BYTE_W +: BYTE_W] <= din2[b*BYTE_W +: BYTE_W];
                    if (en1_m && we1[b]) mem_q[addr1][b*BYTE_W +: BYTE_W] <= din1[b*BYTE_W +: BYTE_W];
                end else begin
                    if (en1_m && we1[b]) mem_q[addr1][b*BYTE_W +: BYTE_W] <= din1[b*BYTE_W +: BYTE_W];
                    if (en2_m && we2[b]) mem_q[addr2][b*BYTE_W +: BYTE_W] <= din2[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            busy_q       <= 1'b1;
            clear_addr_q <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            do1_q        <= '0;
            do2_q        <= '0;
            dv1_q        <= 1'b0;
            dv2_q        <= 1'b0;
            coll1_q      <= 1'b0;
            coll2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            clear_addr_q <= clear_addr_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            do1_q        <= do1_d;
            do2_q        <= do2_d;
            dv1_q        <= dv1_d;
            dv2_q        <= dv2_d;
            coll1_q      <= coll1_d;
            coll2_q      <= coll2_d;
        end
    end

    assign busy        = busy_q;
    assign dout1       = (READ_LAT == 1) ? rd1_q   : do1_q;
    assign dout2       = (READ_LAT == 1) ? rd2_q   : do2_q;
    assign dout1_valid = (READ_LAT == 1) ? v1_q    : dv1_q;
    assign dout2_valid = (READ_LAT == 1) ? v2_q    : dv2_q;
    assign collision   = (READ_LAT == 1) ? coll1_q : coll2_q;

endmodule

// File: doc/tdp_bram_cfg.md
Name: tdp_bram_cfg

Overview:
Parametrised true dual-port block RAM for the sume-sdnet extern library, the successor to the fixed read-first dual-port BRAM used by the bloom filter extern. It adds:
- selectable write mode
- byte-write enables
- 1- or 2-cycle read latency
- read-valid strobes
- cross-port collision detection and deterministic write-write arbitration
- a hardware clear engine that zeroes the array after reset or on request

Both ports share a single clock.

Parameters:
L2_DEPTH, 8, log2 of word count; DEPTH = 2**L2_DEPTH
WIDTH, 32, data width in bits; must be a multiple of BYTE_W
BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W
WRITE_MODE, 0, same-port behaviour: 0 = read-first, 1 = write-first, 2 = no-change
READ_LAT, 2, read latency in cycles (1 or 2); 2 adds an output register gated by regce
PRIO, 1, port that wins a same-address write collision (1 or 2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
clear_req  in  1  one-cycle pulse; starts an array clear when idle
busy  out  1  high while clearing; all port accesses are ignored
en1  in  1  port 1 access enable
we1  in  NB  port 1 byte write enables
addr1  in  L2_DEPTH  port 1 address
din1  in  WIDTH  port 1 write data
regce1  in  1  port 1 output register enable (used only when READ_LAT=2)
dout1  out  WIDTH  port 1 read data
dout1_valid  out  1  port 1 read-data strobe
en2, we2, addr2, din2, regce2, dout2, dout2_valid  (same as port 1, for port 2)
collision  out  1  strobe: same-address access conflict, aligned with the read data

Behaviour:
- Reset (async assert): busy=1; dout1=dout2=0; dout*_valid=0; collision=0; FSM enters CLEAR with clear_addr=0. Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - IDLE: busy=0, ports active.
  - CLEAR: writes 0 to clear_addr each cycle; clear_addr increments.
  - CLEAR -> IDLE: after the write to DEPTH-1. busy stays high for exactly DEPTH cycles after reset release.
  - clear_req in IDLE: CLEAR entered next cycle.
  - clear_req in CLEAR: ignored; the sweep does not restart.
- While busy: en1/en2 are masked internally; no reads or writes take effect; valid strobes stay 0. Any in-flight read pipeline still drains.
- Write: on an enabled cycle, byte lane b of RAM[addr] takes din[b*BYTE_W+:BYTE_W] when we[b]=1. Other lanes are unchanged.
- Same-port read data (stage-1 register), per WRITE_MODE:
  - 0 (read-first): old word.
  - 1 (write-first): merged new word.
  - 2 (no-change): stage-1 holds its previous value on any cycle with |we=1.
- Valid strobe:
  - stage-1 valid = en & ~(WRITE_MODE==2 & |we).
  - READ_LAT=1: dout = stage-1 register; dout_valid = stage-1 valid.
  - READ_LAT=2: stage-2 loads on regce; dout_valid = stage-1 valid & regce, delayed one cycle. When regce=0, dout holds its value and dout_valid=0.
- Collision condition: en1 & en2 & addr1==addr2 & (|we1 | |we2).
  - collision pulses one cycle, READ_LAT cycles after the access.
  - Write-write: per lane, PRIO port data is stored; the other port's data is stored only in lanes the PRIO port does not write.
  - Read vs the other port's write: the reading port returns the old word regardless of WRITE_MODE.
- Same-port read latency is independent of collision.
- Async reset mid-clear or mid-read: all outputs return to reset values immediately; the clear restarts from address 0 on release.

Test Plan:
- Reset release -> busy=1 for DEPTH (256) cycles then 0. Read any address -> 0x00000000, dout_valid=1 after READ_LAT cycles.
- WRITE_MODE=0, port 1: write 0xAABBCCDD to addr 5, then read addr 5 with we1=0x3, din1=0x11112222 -> first dout1=0xAABBCCDD, next read returns 0xAABB2222. Repeat with WRITE_MODE=1 -> first dout1=0xAABB2222.
- Same cycle, addr 9: port1 writes 0x11111111 with we1=0xC; port2 writes 0x22222222 with we2=0xF; PRIO=1 -> RAM[9]=0x11112222; collision=1 after READ_LAT cycles.
- Port 1 reads addr 3 (holds 0x5) while port 2 writes 0x7 to addr 3 -> dout1=0x5, collision=1. A later read of addr 3 -> 0x7.
- READ_LAT=2, regce1=0 on the cycle after a read -> dout1 holds its old value, dout1_valid=0. Issue clear_req mid-traffic -> writes are ignored while busy, and all words read 0 afterwards.
- Assert rst at clear_addr=100 -> outputs go to 0 asynchronously. After release, busy lasts a full 256 cycles.
